// File: rtl/mips_reg_file.sv
// mips_reg_file: 2^ADDR_W x WIDTH register file, one write port, two combinational read ports, optional write-to-read forwarding
//   clk      : clock, writes land on its rising edge
//   rst      : asynchronous active-high reset, clears every register
//   we/wa/wd : write enable, address and data
//   ra1/rd1  : read port 1 address and data
//   ra2/rd2  : read port 2 address and data
module mips_reg_file #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5,
    parameter bit BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [WIDTH-1:0]  wd,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [WIDTH-1:0]  rd1,
    output logic [WIDTH-1:0]  rd2
);
    localparam int N = 1 << ADDR_W;
    logic [WIDTH-1:0] regs_q [N];
    logic [WIDTH-1:0] regs_d [N];
    logic             wr_en;
    logic             fwd1;
    logic             fwd2;
    // register 0 is never written, so it stays at its reset value
    assign wr_en = we && (wa != '0);
    always_comb begin
        regs_d = regs_q;
        if (wr_en)
            regs_d[wa] = wd;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            for (int i = 0; i < N; i++) regs_q[i] <= '0;
        else
            for (int i = 0; i < N; i++) regs_q[i] <= regs_d[i];
    end
    // forwarding only for a write that will actually commit on this edge
    assign fwd1 = BYPASS && !rst && wr_en && (ra1 == wa);
    assign fwd2 = BYPASS && !rst && wr_en && (ra2 == wa);
    // address 0 and reset are forced to zero ahead of the array and the forward path
    assign rd1 = (rst || ra1 == '0) ? '0 : fwd1 ? wd : regs_q[ra1];
    assign rd2 = (rst || ra2 == '0) ? '0 : fwd2 ? wd : regs_q[ra2];
endmodule

// File: tb/tb_mips_reg_file.sv
// tb_mips_reg_file: scoreboard bench driving a forwarding and a non-forwarding register file with the same stimulus
module tb_mips_reg_file;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we  = 1'b0;
    logic [4:0]  wa  = '0;
    logic [31:0] wd  = '0;
    logic [4:0]  ra1 = '0;
    logic [4:0]  ra2 = '0;
    logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] model [32];
    logic [127:0] exp_q [$];
    string        name_q [$];
    event         chk_ev;

    mips_reg_file #(.WIDTH(32), .ADDR_W(5), .BYPASS(1'b1)) dut_b (
        .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd),
        .ra1(ra1), .ra2(ra2), .rd1(rd1_b), .rd2(rd2_b)
    );
    mips_reg_file #(.WIDTH(32), .ADDR_W(5), .BYPASS(1'b0)) dut_n (
        .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd),
        .ra1(ra1), .ra2(ra2), .rd1(rd1_n), .rd2(rd2_n)
    );

    always #5 clk = ~clk;

    // reference contents: reset wipes everything, a committed write lands on the edge
    always @(posedge clk or posedge rst) begin
        if (rst)
            for (int i = 0; i < 32; i++) model[i] <= '0;
        else if (we && wa != 5'd0)
            model[wa] <= wd;
    end

    function automatic logic [31:0] exp_rd(input logic [4:0] ra, input bit byp);
        if (rst || ra == 5'd0) return 32'h0;
        if (byp && we && wa != 5'd0 && wa == ra) return wd;
        return model[ra];
    endfunction

    task automatic check(input string nm);
        #1;
        exp_q.push_back({exp_rd(ra1, 1'b1), exp_rd(ra2, 1'b1), exp_rd(ra1, 1'b0), exp_rd(ra2, 1'b0)});
        name_q.push_back(nm);
        ->chk_ev;
        #1;
    endtask

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    initial begin
        logic [127:0] e;
        string        nm;
        forever begin
            @(chk_ev);
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            cmp({nm, " byp.rd1"}, rd1_b, e[127:96]);
            cmp({nm, " byp.rd2"}, rd2_b, e[95:64]);
            cmp({nm, " nobyp.rd1"}, rd1_n, e[63:32]);
            cmp({nm, " nobyp.rd2"}, rd2_n, e[31:0]);
        end
    end

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        we = 1'b1; wa = a; wd = d;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    initial begin
        logic [7:0] b;
        // reset state
        repeat (2) @(negedge clk);
        for (int a = 0; a < 32; a += 7) begin
            ra1 = 5'(a); ra2 = 5'(31 - a);
            check("reset_state");
        end
        @(negedge clk);
        rst = 1'b0;
        // fill, then asynchronous reset mid-cycle with a live matching write
        for (int a = 1; a < 32; a++) wr(5'(a), 32'hAAAAAAAA);
        @(negedge clk);
        ra1 = 5'd9; ra2 = 5'd31;
        check("filled");
        #1;
        rst = 1'b1;
        for (int a = 0; a < 32; a++) begin
            we = 1'b1; wa = 5'(a); wd = 32'h5A5A5A5A;
            ra1 = 5'(a); ra2 = 5'(31 - a);
            check("async_reset");
        end
        @(negedge clk);
        we = 1'b0; rst = 1'b0;
        ra1 = 5'd4; ra2 = 5'd17;
        check("post_reset");
        // write, read back on the other port
        wr(5'd5, 32'h55555555);
        ra1 = 5'd5; ra2 = 5'd6;
        check("wr5_read");
        wr(5'd31, 32'hFFFFFFFF);
        ra2 = 5'd31;
        check("wr31_read");
        // register 0 immutable
        ra1 = 5'd0; ra2 = 5'd0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            we = 1'b1; wa = 5'd0; wd = 32'hDDDDDDDD;
            check("r0_during_write");
        end
        @(negedge clk);
        we = 1'b0;
        check("r0_after_write");
        // forwarding vs old value
        wr(5'd7, 32'h12345678);
        @(negedge clk);
        we = 1'b1; wa = 5'd7; wd = 32'hA5A5A5A5; ra1 = 5'd7; ra2 = 5'd7;
        check("bypass_same_cycle");
        @(posedge clk);
        #1;
        we = 1'b0;
        check("bypass_after_edge");
        // we gating
        @(negedge clk);
        we = 1'b0; wa = 5'd3; wd = 32'hFFFFFFFF; ra1 = 5'd3; ra2 = 5'd3;
        @(posedge clk);
        #1;
        check("we_gating");
        // reset racing a write edge
        @(negedge clk);
        we = 1'b1; wa = 5'd3; wd = 32'hCAFEBABE;
        @(posedge clk);
        rst = 1'b1;
        @(negedge clk);
        we = 1'b0; rst = 1'b0;
        check("reset_race");
        wr(5'd3, 32'h00000001);
        check("first_post_reset_write");
        // decode walk
        for (int a = 1; a < 32; a++) begin
            b = 8'(a);
            wr(5'(a), {b, b, b, b});
        end
        for (int a = 0; a < 32; a++) begin
            ra1 = 5'(a); ra2 = 5'(a ^ 1);
            check("decode_walk");
        end
        // random traffic
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            we  = 1'($urandom_range(0, 1));
            wa  = 5'($urandom_range(0, 31));
            wd  = $urandom;
            ra1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            ra2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            check("random");
        end
        @(negedge clk);
        we = 1'b0;
        #5;
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d checks left unchecked, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/mips_reg_file.md
Name: mips_reg_file

Overview:
- MIPS general-purpose register file: 2^ADDR_W registers of WIDTH bits each.
- The write side fans one data word out to exactly one register, selected by a write-address decode.
- The two read sides each select one register onto an output port.
- Sits between the decode stage (read ports) and the write-back stage (write port). Its read outputs feed the ALU operand select.

Parameters:
- WIDTH, 32, data width of each register and of every data port.
- ADDR_W, 5, register address width; the file holds 2^ADDR_W registers.
- BYPASS, 1, 1 = a same-cycle write is forwarded to a matching read port; 0 = no forwarding.

Ports:
- clk  input  1  clock; all writes occur on its rising edge.
- rst  input  1  asynchronous, active-high reset; clears every register.
- we  input  1  write enable.
- wa  input  ADDR_W  write address.
- wd  input  WIDTH  write data.
- ra1  input  ADDR_W  read address, port 1.
- ra2  input  ADDR_W  read address, port 2.
- rd1  output  WIDTH  read data, port 1.
- rd2  output  WIDTH  read data, port 2.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset:
  - rst assertion clears all registers to 0 immediately, with no clock edge required.
  - While rst=1, rd1 and rd2 read 0 for every address. Writes are ignored and bypass is suppressed.
  - Release of rst: the first write takes effect on the first rising edge of clk after rst falls.
  - Reset asserted mid-operation discards any write pending on that edge. No partial update is allowed.
- Write:
  - On the rising edge of clk with rst=0 and we=1, reg[wa] <= wd.
  - Exactly one register changes per write; all others hold.
  - we=0 leaves every register unchanged.
- Register 0:
  - Hardwired to 0. Writes to wa=0 are silently dropped.
  - Reads of address 0 always return 0, including the bypass case.
- Read:
  - Combinational, with zero latency: rd1 = reg[ra1] and rd2 = reg[ra2].
  - Outputs update within the same cycle when an address changes.
  - A write becomes visible through the array on the cycle after its edge.
- Bypass (BYPASS=1):
  - If we=1, rst=0, wa!=0 and ra1==wa, then rd1 = wd combinationally in the same cycle. rd2 follows the same rule with ra2.
  - If both ports match wa, both receive wd.
- No bypass (BYPASS=0): a read of wa during the write cycle returns the old value. The new value appears after the edge.
- Simultaneous events:
  - Two read ports at the same address return identical data.
  - A read and a write to the same address follow the BYPASS rule above.
  - Back-to-back writes to one address: the last edge wins.
- X handling:
  - we=X or wa=X are illegal stimulus. The design need not define the result.
  - ra=X may produce X on the corresponding output only.
- Width rule: no truncation or extension. WIDTH bits in, WIDTH bits out.

Test Plan:
- Reset clears all: write 32'hAAAAAAAA to regs 1..31; assert rst mid-cycle with no clk edge -> rd1 and rd2 read 32'h00000000 for all 32 addresses before the next edge.
- Write/readback on the other port: we=1, wa=5, wd=32'h55555555, then on the next cycle ra1=5, ra2=6 -> rd1=32'h55555555, rd2=32'h00000000. Repeat with wa=31, wd=32'hFFFFFFFF -> ra2=31 reads 32'hFFFFFFFF.
- Register 0 immutable: we=1, wa=0, wd=32'hDDDDDDDD for 3 edges; ra1=ra2=0 -> both read 0, including during the write cycle with BYPASS=1.
- Bypass:
  - BYPASS=1 setup: reg 7 = 32'h12345678.
  - Stimulus: in a single cycle, we=1, wa=7, wd=32'hA5A5A5A5, ra1=ra2=7.
  - Response: both outputs read 32'hA5A5A5A5 before the edge.
  - BYPASS=0, same stimulus: both outputs read 32'h12345678 before the edge and 32'hA5A5A5A5 after it.
- we gating and reset-vs-write race:
  - we=0, wa=3, wd=32'hFFFFFFFF -> reg 3 stays 0.
  - Assert rst coincident with a we=1 edge to reg 3 -> reg 3 reads 0 after rst falls.
  - First post-reset edge with we=1, wa=3, wd=32'h00000001 -> reg 3 reads 32'h00000001.
- Decode isolation: walk wa=1..31, writing wd=wa replicated in each byte (e.g. 32'h09090909 for wa=9) -> readback of all 32 addresses matches, and no aliasing across addresses.
